store_buffer: RTL

//  Posted-write buffer between the core's load/store port and Data_memory.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/sb_fifo.sv | 57 +++++
 rtl/store_buffer.sv | 110 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared memory-access definitions: funct3 encodings, store entry layout and access-span helpers.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 13;
  localparam int unsigned MEM_WIDTH  = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Entry layout for the default memory geometry; the FIFO stores it as {addr, funct3, wdata}.
  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [2:0]            funct3;
    logic [MEM_WIDTH-1:0]  wdata;
  } sb_entry_t;

  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3)
      F3_B, F3_BU: size = 3'd1;
      F3_H, F3_HU: size = 3'd2;
      F3_W:        size = 3'd4;
      default:     size = 3'd4;
    endcase
    return size;
  endfunction

  // True when the access crosses into the next word.
  function automatic logic spans_next(input logic [1:0] offset, input logic [2:0] funct3);
    return ({1'b0, offset} + size_of(funct3)) > 3'd4;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Register FIFO for queued stores; exposes every slot and its valid bit for hazard compare.
module sb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned EW    = 48
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [EW-1:0]            wdata_i,
  output logic [EW-1:0]            head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [DEPTH-1:0]         valid_o,
  output logic [DEPTH*EW-1:0]      entries_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [EW-1:0]  mem_q [DEPTH];
  logic [PW-1:0]  wr_q, rd_q;
  logic [PW:0]    cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) begin
        rd_q <= rd_q + 1'b1;
      end
      if (push_i && !pop_i) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!push_i && pop_i) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    valid_o   = '0;
    entries_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_o[i]            = {1'b0, PW'(PW'(i) - rd_q)} < cnt_q;
      entries_o[i*EW +: EW] = mem_q[i];
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: loads bypass queued stores unless they overlap one; stores drain when idle.
module store_buffer
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned WIDTH  = MEM_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [WIDTH-1:0]  req_wdata_i,
  output logic              req_ready_o,
  output logic              ld_valid_o,
  output logic [WIDTH-1:0]  ld_data_o,
  output logic              sb_empty_o,
  output logic              mem_st_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [2:0]        mem_funct3_o,
  output logic [WIDTH-1:0]  mem_st_data_o,
  input  logic [WIDTH-1:0]  mem_ld_data_i
);

  localparam int unsigned EW = ADDR_W + 3 + WIDTH;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned WW = ADDR_W - 2;

  logic [EW-1:0]       head;
  logic [DEPTH*EW-1:0] entries;
  logic [DEPTH-1:0]    valid;
  logic [CW-1:0]       count;
  logic                full, overlap, st_acc, ld_acc, drain;
  logic                ld_valid_q;
  logic [WIDTH-1:0]    ld_hold_q;

  sb_fifo #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (st_acc),
    .pop_i     (drain),
    .wdata_i   ({req_addr_i, req_funct3_i, req_wdata_i}),
    .head_o    (head),
    .count_o   (count),
    .valid_o   (valid),
    .entries_o (entries)
  );

  // Word-index overlap of the requested load against every live entry, incl. next-word spill.
  always_comb begin
    logic [WW-1:0]     ld_w0, ld_w1, e_w0, e_w1;
    logic              ld_sp, e_sp;
    logic [ADDR_W-1:0] e_addr;
    logic [2:0]        e_f3;
    ld_w0   = req_addr_i[ADDR_W-1:2];
    ld_w1   = ld_w0 + 1'b1;
    ld_sp   = spans_next(req_addr_i[1:0], req_funct3_i);
    e_w0    = '0;
    e_w1    = '0;
    e_sp    = 1'b0;
    e_addr  = '0;
    e_f3    = '0;
    overlap = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      e_addr = entries[i*EW + WIDTH + 3 +: ADDR_W];
      e_f3   = entries[i*EW + WIDTH +: 3];
      e_w0   = e_addr[ADDR_W-1:2];
      e_w1   = e_w0 + 1'b1;
      e_sp   = spans_next(e_addr[1:0], e_f3);
      if (valid[i] && ((e_w0 == ld_w0) || (ld_sp && (e_w0 == ld_w1)) ||
                       (e_sp && (e_w1 == ld_w0)))) begin
        overlap = 1'b1;
      end
    end
  end

  assign full   = (count == CW'(DEPTH));
  assign st_acc = req_valid_i && req_we_i && !full;
  assign ld_acc = req_valid_i && !req_we_i && !overlap;
  assign drain  = !ld_acc && (count != '0);

  assign req_ready_o   = req_we_i ? !full : !overlap;
  assign sb_empty_o    = (count == '0);
  assign mem_st_en_o   = drain;
  assign mem_addr_o    = ld_acc ? req_addr_i   : head[EW-1 -: ADDR_W];
  assign mem_funct3_o  = ld_acc ? req_funct3_i : head[WIDTH +: 3];
  assign mem_st_data_o = head[WIDTH-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_valid_q <= 1'b0;
      ld_hold_q  <= '0;
    end else begin
      ld_valid_q <= ld_acc;
      if (ld_valid_q) begin
        ld_hold_q <= mem_ld_data_i;
      end
    end
  end

  // Read data arrives one cycle after the address, so the return cycle passes it straight out.
  assign ld_valid_o = ld_valid_q;
  assign ld_data_o  = ld_valid_q ? mem_ld_data_i : ld_hold_q;

endmodule
